// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock FIFO: default sizes, depth and count-width helpers,
// and the per-edge operation encoding used by the occupancy counter.
package fifo_pkg;

    localparam int DEF_DATA_SIZE    = 8;
    localparam int DEF_ADDRESS_SIZE = 5;

    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_BOTH  = 2'b11
    } fifo_op_e;

    function automatic int fifo_depth(input int address_size);
        return int'(32'd1 << address_size);
    endfunction

    function automatic int count_width(input int address_size);
        return address_size + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage for sync_fifo: gated write port, registered read port.
// Only the read register is reset; the array itself keeps whatever it held.
module sync_fifo_ram
    import fifo_pkg::*;
#(
    parameter int data_Size    = DEF_DATA_SIZE,
    parameter int address_Size = DEF_ADDRESS_SIZE
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    w_En,
    input  logic [address_Size-1:0] w_Addr,
    input  logic [data_Size-1:0]    w_Data,
    input  logic                    r_En,
    input  logic [address_Size-1:0] r_Addr,
    output logic [data_Size-1:0]    r_Data
);

    localparam int DEPTH = fifo_depth(address_Size);

    logic [data_Size-1:0] mem_r [DEPTH];
    logic [data_Size-1:0] r_data_r;

    // Storage array write port
    always_ff @(posedge Clk) begin
        if (w_En) begin
            mem_r[w_Addr] <= w_Data;
        end else begin
            mem_r[w_Addr] <= mem_r[w_Addr];
        end
    end

    // Registered read port; holds its value when no read is enabled
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_data_r <= {data_Size{1'b0}};
        end else if (r_En) begin
            r_data_r <= mem_r[r_Addr];
        end else begin
            r_data_r <= r_data_r;
        end
    end

    assign r_Data = r_data_r;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointers, occupancy count, status flags and sticky error flags
// around a dual-port RAM with a registered read port.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int data_Size        = DEF_DATA_SIZE,
    parameter int address_Size     = DEF_ADDRESS_SIZE,
    parameter int almost_Full_Lvl  = 28,
    parameter int almost_Empty_Lvl = 4
) (
    input  logic                            Clk,
    input  logic                            Rst,
    input  logic                            w_Enable,
    input  logic [data_Size-1:0]            write_Data,
    input  logic                            r_Enable,
    output logic [data_Size-1:0]            read_Data,
    output logic                            read_Valid,
    output logic                            fifo_Full,
    output logic                            fifo_Empty,
    output logic                            almost_Full,
    output logic                            almost_Empty,
    output logic [count_width(address_Size)-1:0] fill_Count,
    output logic                            overflow,
    output logic                            underflow,
    input  logic                            err_Clr
);

    localparam int                DEPTH    = fifo_depth(address_Size);
    localparam int                CW       = count_width(address_Size);
    localparam logic [CW-1:0]     DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0]     AFULL_C  = CW'(almost_Full_Lvl);
    localparam logic [CW-1:0]     AEMPTY_C = CW'(almost_Empty_Lvl);
    localparam logic [CW-1:0]     ONE_C    = {{address_Size{1'b0}}, 1'b1};

    generate
        if ((almost_Empty_Lvl < 0) || (almost_Empty_Lvl >= almost_Full_Lvl) ||
            (almost_Full_Lvl > DEPTH)) begin : g_bad_levels
            $error("sync_fifo: need 0 <= almost_Empty_Lvl < almost_Full_Lvl <= depth");
        end
    endgenerate

    logic [CW-1:0] wptr_r;
    logic [CW-1:0] rptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_nxt_s;
    logic          read_valid_r;
    logic          overflow_r;
    logic          underflow_r;
    logic          wr_ok_s;
    logic          rd_ok_s;
    fifo_op_e      op_s;

    // Flags come straight from the registered count, so they only move on Clk
    assign fifo_Full    = (count_r == DEPTH_C);
    assign fifo_Empty   = (count_r == {CW{1'b0}});
    assign almost_Full  = (count_r >= AFULL_C);
    assign almost_Empty = (count_r <= AEMPTY_C);
    assign fill_Count   = count_r;
    assign read_Valid   = read_valid_r;
    assign overflow     = overflow_r;
    assign underflow    = underflow_r;

    assign wr_ok_s = w_Enable && !fifo_Full;
    assign rd_ok_s = r_Enable && !fifo_Empty;

    // Classify this edge's accepted operations and derive the next occupancy
    always_comb begin
        op_s        = OP_IDLE;
        count_nxt_s = count_r;
        case ({wr_ok_s, rd_ok_s})
            2'b10:   op_s = OP_WRITE;
            2'b01:   op_s = OP_READ;
            2'b11:   op_s = OP_BOTH;
            default: op_s = OP_IDLE;
        endcase
        case (op_s)
            OP_WRITE: count_nxt_s = count_r + ONE_C;
            OP_READ:  count_nxt_s = count_r - ONE_C;
            OP_BOTH:  count_nxt_s = count_r;
            default:  count_nxt_s = count_r;
        endcase
    end

    // Pointers, occupancy and read strobe; the pointer MSB is the wrap bit
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            wptr_r       <= {CW{1'b0}};
            rptr_r       <= {CW{1'b0}};
            count_r      <= {CW{1'b0}};
            read_valid_r <= 1'b0;
        end else begin
            wptr_r       <= wr_ok_s ? (wptr_r + ONE_C) : wptr_r;
            rptr_r       <= rd_ok_s ? (rptr_r + ONE_C) : rptr_r;
            count_r      <= count_nxt_s;
            read_valid_r <= rd_ok_s;
        end
    end

    // Sticky error flags: a new violation outranks a same-cycle clear
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (w_Enable && fifo_Full) begin
                overflow_r <= 1'b1;
            end else if (err_Clr) begin
                overflow_r <= 1'b0;
            end else begin
                overflow_r <= overflow_r;
            end
            if (r_Enable && fifo_Empty) begin
                underflow_r <= 1'b1;
            end else if (err_Clr) begin
                underflow_r <= 1'b0;
            end else begin
                underflow_r <= underflow_r;
            end
        end
    end

    sync_fifo_ram #(
        .data_Size    (data_Size),
        .address_Size (address_Size)
    ) u_ram (
        .Clk    (Clk),
        .Rst    (Rst),
        .w_En   (wr_ok_s),
        .w_Addr (wptr_r[address_Size-1:0]),
        .w_Data (write_Data),
        .r_En   (rd_ok_s),
        .r_Addr (rptr_r[address_Size-1:0]),
        .r_Data (read_Data)
    );

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo at depth 4: expected words are queued on accepted writes
// and compared when the read strobe is expected; flags and errors come from a small model.
module tb_sync_fifo;

    localparam int DW    = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 4;
    localparam int AFL   = 3;
    localparam int AEL   = 1;

    logic          Clk = 1'b0;
    logic          Rst = 1'b0;
    logic          w_Enable = 1'b0;
    logic [DW-1:0] write_Data = 8'h00;
    logic          r_Enable = 1'b0;
    logic          err_Clr = 1'b0;
    logic [DW-1:0] read_Data;
    logic          read_Valid;
    logic          fifo_Full;
    logic          fifo_Empty;
    logic          almost_Full;
    logic          almost_Empty;
    logic [AW:0]   fill_Count;
    logic          overflow;
    logic          underflow;

    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] last_rd = 8'h00;
    logic          m_ovf = 1'b0;
    logic          m_udf = 1'b0;
    int            n_checks = 0;
    int            n_pass = 0;

    sync_fifo #(
        .data_Size        (DW),
        .address_Size     (AW),
        .almost_Full_Lvl  (AFL),
        .almost_Empty_Lvl (AEL)
    ) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .w_Enable     (w_Enable),
        .write_Data   (write_Data),
        .r_Enable     (r_Enable),
        .read_Data    (read_Data),
        .read_Valid   (read_Valid),
        .fifo_Full    (fifo_Full),
        .fifo_Empty   (fifo_Empty),
        .almost_Full  (almost_Full),
        .almost_Empty (almost_Empty),
        .fill_Count   (fill_Count),
        .overflow     (overflow),
        .underflow    (underflow),
        .err_Clr      (err_Clr)
    );

    always #5 Clk = ~Clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input logic exp_valid);
        int n;
        n = exp_q.size();
        check_val("read_Valid", 32'(read_Valid), 32'(exp_valid));
        check_val("read_Data", 32'(read_Data), 32'(last_rd));
        check_val("fill_Count", 32'(fill_Count), 32'(n));
        check_val("fifo_Full", 32'(fifo_Full), 32'(n == DEPTH));
        check_val("fifo_Empty", 32'(fifo_Empty), 32'(n == 0));
        check_val("almost_Full", 32'(almost_Full), 32'(n >= AFL));
        check_val("almost_Empty", 32'(almost_Empty), 32'(n <= AEL));
        check_val("overflow", 32'(overflow), 32'(m_ovf));
        check_val("underflow", 32'(underflow), 32'(m_udf));
    endtask

    // One clock: drive the request, predict the outcome, then check after the edge
    task automatic step(input logic w, input logic [DW-1:0] wd, input logic r, input logic ec);
        logic wr_ok;
        logic rd_ok;
        int   n;
        w_Enable   = w;
        write_Data = wd;
        r_Enable   = r;
        err_Clr    = ec;
        n     = exp_q.size();
        wr_ok = w && (n < DEPTH);
        rd_ok = r && (n > 0);
        if (w && (n == DEPTH)) m_ovf = 1'b1;
        else if (ec)           m_ovf = 1'b0;
        if (r && (n == 0))     m_udf = 1'b1;
        else if (ec)           m_udf = 1'b0;
        if (rd_ok) last_rd = exp_q.pop_front();
        if (wr_ok) exp_q.push_back(wd);
        @(posedge Clk);
        #1;
        w_Enable = 1'b0;
        r_Enable = 1'b0;
        err_Clr  = 1'b0;
        check_outputs(rd_ok);
    endtask

    task automatic model_reset();
        exp_q.delete();
        last_rd = 8'h00;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
    endtask

    initial begin
        // Power-on reset, checked while still asserted
        #1 Rst = 1'b1;
        #2;
        model_reset();
        check_outputs(1'b0);
        @(posedge Clk);
        @(posedge Clk);
        #1 Rst = 1'b0;
        step(1'b0, 8'h00, 1'b0, 1'b0);

        // Fill to full, then one write too many
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hA1 + i), 1'b0, 1'b0);
        step(1'b1, 8'hA5, 1'b0, 1'b0);

        // Drain, then one read too many
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Simultaneous write+read at full, then at empty
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hA1 + i), 1'b0, 1'b0);
        step(1'b1, 8'hB0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'hC0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Streaming at count 2 across several pointer wraps
        step(1'b1, 8'h10, 1'b0, 1'b0);
        step(1'b1, 8'h11, 1'b0, 1'b0);
        for (int i = 2; i < 10; i++) step(1'b1, 8'(8'h10 + i), 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Error clear, including a clear that coincides with a new overflow
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hD0 + i), 1'b0, 1'b0);
        step(1'b1, 8'hD4, 1'b0, 1'b0);
        step(1'b1, 8'hD5, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 8'hD6, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Reset mid-stream at count 3 with overflow set
        Rst = 1'b1;
        #2;
        model_reset();
        check_outputs(1'b0);
        @(posedge Clk);
        #1 Rst = 1'b0;
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 8'hE0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
Single-clock, parametrised FIFO that succeeds the dual-port FIFO memory. It adds the following, all inside one block:
- read/write pointers and occupancy count
- registered read data with a valid strobe
- full/empty and programmable almost-full/almost-empty flags
- sticky overflow/underflow error flags
It is used wherever producer and consumer share one clock domain. No gray-code synchronisers are needed.

Parameters:
data_Size, 8, width of each data word in bits
address_Size, 5, pointer width; depth = 1<<address_Size entries (exactly, no spare slot)
almost_Full_Lvl, 28, almost_Full asserts when fill_Count >= this value
almost_Empty_Lvl, 4, almost_Empty asserts when fill_Count <= this value

Ports:
Clk  input  1  clock, all logic on rising edge
Rst  input  1  asynchronous, active-high reset
w_Enable  input  1  write request
write_Data  input  data_Size  data to write
r_Enable  input  1  read request
read_Data  output  data_Size  registered read data
read_Valid  output  1  read_Data holds a newly read word this cycle
fifo_Full  output  1  fill_Count == depth
fifo_Empty  output  1  fill_Count == 0
almost_Full  output  1  fill_Count >= almost_Full_Lvl
almost_Empty  output  1  fill_Count <= almost_Empty_Lvl
fill_Count  output  address_Size+1  current occupancy, 0..depth
overflow  output  1  sticky: a write was attempted while full
underflow  output  1  sticky: a read was attempted while empty
err_Clr  input  1  synchronous clear of overflow/underflow

Behaviour:
- Reset (async assert, sync-to-Clk deassert is upstream's job):
  - pointers = 0, fill_Count = 0, read_Data = 0, read_Valid = 0
  - fifo_Empty = 1, fifo_Full = 0, almost_Empty = 1, almost_Full = 0
  - overflow = 0, underflow = 0
  - Memory contents are not reset.
- Pointers are address_Size+1 bits; the MSB is the wrap bit; memory is indexed by the low address_Size bits.
- Write accepted (wr_ok) = w_Enable && !fifo_Full, where fifo_Full is the pre-edge value. On wr_ok, mem[wptr] <= write_Data and wptr increments.
- Read accepted (rd_ok) = r_Enable && !fifo_Empty, using the pre-edge value. On rd_ok, read_Data <= mem[rptr] at that edge, rptr increments, and read_Valid = 1 for the following cycle. Latency: r_Enable at edge N gives data/valid visible after edge N.
- read_Data holds its value when no read is accepted; read_Valid = 0 on those cycles.
- fill_Count next value:
  - +1 on wr_ok only
  - -1 on rd_ok only
  - unchanged when both or neither are accepted
- All flags are derived combinationally from the registered fill_Count. They are glitch-free relative to Clk and update the cycle after the accepting edge.
- Boundary rules:
  - Full with simultaneous write and read: the read is accepted, the write is rejected (overflow sets) and count becomes depth-1.
  - Empty with simultaneous write and read: the write is accepted, the read is rejected (underflow sets), count becomes 1, read_Valid = 0. No fall-through.
  - Rejected operations never move pointers or modify memory.
  - Wrap-around: pointer low bits wrap 2^address_Size-1 -> 0 and the wrap bit toggles. Data order is preserved across the wrap.
- Error flags:
  - overflow sets on w_Enable && fifo_Full.
  - underflow sets on r_Enable && fifo_Empty.
  - Both clear only on Rst or err_Clr. If set and clear conditions coincide in the same cycle, set wins.
- Reset asserted mid-operation empties the FIFO immediately. Data in memory is discarded logically.
- Required parameter relation: 0 <= almost_Empty_Lvl < almost_Full_Lvl <= depth. Flag any violation with an elaboration-time check.

Decomposition:
- Shared package fifo_pkg:
  - depth function (1<<address_Size)
  - default data_Size/address_Size constants
  - count width helper (address_Size+1)
- One sub-module, sync_fifo_ram: simple dual-port RAM with a write port gated by a write enable and a registered read port with a read enable. Depth exactly 1<<address_Size.
- sync_fifo contains the pointers, count, flags and error logic.

Test Plan:
All tests use data_Size=8, address_Size=2 (depth 4), almost_Full_Lvl=3, almost_Empty_Lvl=1.
- Reset then idle -> fifo_Empty=1, almost_Empty=1, fill_Count=0, read_Valid=0, read_Data=0x00.
- Write 0xA1,0xA2,0xA3,0xA4 -> fifo_Full=1, almost_Full=1 after count reaches 3. A fifth write of 0xA5 sets overflow=1 and count stays 4.
- Read 4 times from full -> read_Data 0xA1..0xA4 each one cycle after r_Enable, read_Valid high 4 cycles. A fifth read sets underflow=1, read_Valid=0, read_Data holds 0xA4.
- Fill to 4, then simultaneous write 0xB0 and read -> 0xA1 returned, write rejected, count 3, overflow=1. At empty, simultaneous write 0xC0 and read -> count 1, read_Valid=0, underflow=1.
- 10 write/read pairs of 0x10..0x19 at steady count 2 (pointers wrap twice) -> outputs in order 0x10..0x19, no error flags set.
- Assert Rst mid-stream at count 3 -> next cycle count 0, fifo_Empty=1, errors cleared. err_Clr pulse with overflow set -> overflow=0 next cycle.
